// File: rtl/lifi_pam_pkg.sv
// Shared LiFi PAM-4 definitions: frame geometry, lane levels, fill FSM states
// and the receiver-side slicer that undoes the transmit level mapping.
package lifi_pam_pkg;

  localparam int PAM_M    = 8;
  localparam int PAM_N    = 16;
  localparam int PAM_LOGN = 4;
  localparam int PAM_LW   = PAM_M + PAM_LOGN;
  localparam int PAM_PSUM = 2 ** (PAM_LOGN - 1);

  localparam int PAM_LVL0 = -8;
  localparam int PAM_LVL1 = 8;
  localparam int PAM_LVL2 = 24;
  localparam int PAM_LVL3 = 40;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fill_state_t;

  // Biasing by PSUM centres each level inside a 16-wide band split at 8/24/40.
  function automatic logic [1:0] pam4_demap(input logic signed [PAM_LW-1:0] lvl);
    int biased;
    biased = int'(lvl) + PAM_PSUM;
    if (biased < 8)       return 2'd0;
    else if (biased < 24) return 2'd1;
    else if (biased < 40) return 2'd2;
    else                  return 2'd3;
  endfunction

endpackage

// File: rtl/pam4_level_map.sv
// Combinational PAM-4 symbol to signed lane level (16*s - 8).
module pam4_level_map
  import lifi_pam_pkg::*;
#(
  parameter int M    = PAM_M,
  parameter int logN = PAM_LOGN
) (
  input  logic        [M/4-1:0]    sym,
  output logic signed [M+logN-1:0] level
);

  always_comb begin
    case (sym)
      (M/4)'(0): level = (M+logN)'(PAM_LVL0);
      (M/4)'(1): level = (M+logN)'(PAM_LVL1);
      (M/4)'(2): level = (M+logN)'(PAM_LVL2);
      default:   level = (M+logN)'(PAM_LVL3);
    endcase
  end

endmodule

// File: rtl/bias_map.sv
// Collects N-1 PAM-4 symbols into a frame of signed lanes (first symbol in the top lane,
// lane 0 always zero) and holds the frame until the downstream handshake.
module bias_map
  import lifi_pam_pkg::*;
#(
  parameter int M    = PAM_M,
  parameter int N    = PAM_N,
  parameter int logN = PAM_LOGN
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sym_valid,
  input  logic [M/4-1:0]            sym_in,
  output logic                      sym_ready,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [N*(M+logN)-1:0]     u,
  output logic [7:0]                frame_cnt
);

  localparam int LW = M + logN;

  fill_state_t        state, state_nxt;
  logic [logN-1:0]    fill_cnt;
  logic               rdy_armed;
  logic               accept;
  logic               last_sym;
  logic               release_frame;
  logic signed [LW-1:0] level;
  logic [LW-1:0]      lane_q [1:N-1];

  pam4_level_map #(.M(M), .logN(logN)) u_level_map (
    .sym   (sym_in),
    .level (level)
  );

  // Keeps sym_ready low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_armed <= 1'b0;
    else        rdy_armed <= 1'b1;
  end

  assign sym_ready     = rdy_armed && (state == FILL);
  assign out_valid     = (state == HOLD);
  assign accept        = sym_valid && sym_ready && !flush;
  assign last_sym      = (fill_cnt == logN'(N - 2));
  assign release_frame = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && last_sym) state_nxt = HOLD;
      HOLD:    if (out_ready)          state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
    end else if (release_frame || (state == FILL && flush)) begin
      fill_cnt <= '0;
    end else if (accept) begin
      fill_cnt <= fill_cnt + logN'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k < N; k++) lane_q[k] <= '0;
    end else if (accept) begin
      for (int k = 1; k < N; k++) begin
        if (fill_cnt == logN'(N - 1 - k)) lane_q[k] <= level;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             frame_cnt <= 8'd0;
    else if (release_frame) frame_cnt <= frame_cnt + 8'd1;
  end

  always_comb begin
    u = '0;
    for (int k = 1; k < N; k++) u[k*LW +: LW] = lane_q[k];
  end

endmodule
